apb_master_ctrl: RTL and testbench

APB requester (master) that converts a simple valid/ready command interface into single APB4 transfers. It drives the APB slaves in the design, including the SRAM-backed register/memory slaves. It runs the SETUP/ACCESS sequence, honours slave wait states, and captures PRDATA/PSLVERR. It returns a one-cycle response per command and aborts stalled transfers with a timeout error.

---
 rtl/apb_master_ctrl.sv | 135 +++++++++++++
 tb/tb_apb_master_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// Purpose : APB4 requester; turns one valid/ready command into one APB SETUP/ACCESS transfer.
// Latency : accept edge -> SETUP -> ACCESS (+wait states) -> one-cycle response 3 cycles after accept.
// Backpr. : oCMD_READY only in IDLE (1 transfer per 3 cycles max); responses cannot be stalled.
//
// Ports:
//   iPCLK / iPRESETn              clock, asynchronous active-low reset
//   iCMD_* / oCMD_READY           command channel (write, addr, wdata, strb)
//   oRSP_VALID/RDATA/ERR          one-cycle response pulse; data/err zero outside the pulse
//   oPSEL..oPWDATA, iPRDATA,
//   iPREADY, iPSLVERR             APB4 requester interface
module apb_master_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int TMR_W       = 8
) (
    input  logic        iPCLK,
    input  logic        iPRESETn,
    input  logic        iCMD_VALID,
    output logic        oCMD_READY,
    input  logic        iCMD_WRITE,
    input  logic [15:0] iCMD_ADDR,
    input  logic [31:0] iCMD_WDATA,
    input  logic [3:0]  iCMD_STRB,
    output logic        oRSP_VALID,
    output logic [31:0] oRSP_RDATA,
    output logic        oRSP_ERR,
    output logic        oPSEL,
    output logic        oPENABLE,
    output logic        oPWRITE,
    output logic [3:0]  oPSTRB,
    output logic [15:0] oPADDR,
    output logic [31:0] oPWDATA,
    input  logic [31:0] iPRDATA,
    input  logic        iPREADY,
    input  logic        iPSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam bit              TMO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMO_EN ? TMR_W'(TIMEOUT_CYC - 1) : '0;

    state_t           r_state;
    state_t           w_next;
    logic [TMR_W-1:0] r_tmr;

    logic        r_pwrite;
    logic [3:0]  r_pstrb;
    logic [15:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_rsp_vld;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic w_accept;
    logic w_done;
    logic w_abort;

    // Ready is gated by the reset pin so it reads 0 while reset is held,
    // even though the state register already sits at IDLE.
    assign oCMD_READY = (r_state == S_IDLE) & iPRESETn;
    assign w_accept   = iCMD_VALID & oCMD_READY;
    assign w_done     = (r_state == S_ACCESS) & iPREADY;
    assign w_abort    = (r_state == S_ACCESS) & ~iPREADY & TMO_EN & (r_tmr == TMR_LAST);

    always_ff @(posedge iPCLK or negedge iPRESETn) begin
        if (!iPRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_done || w_abort) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iPCLK or negedge iPRESETn) begin
        if (!iPRESETn) begin
            r_tmr       <= '0;
            r_pwrite    <= 1'b0;
            r_pstrb     <= 4'h0;
            r_paddr     <= 16'h0;
            r_pwdata    <= 32'h0;
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Response fields are pulses: zero unless a transfer ends this edge.
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;

            if (w_accept) begin
                // Reads never drive strobes or write data onto the bus.
                r_pwrite <= iCMD_WRITE;
                r_paddr  <= iCMD_ADDR;
                r_pstrb  <= iCMD_WRITE ? iCMD_STRB  : 4'h0;
                r_pwdata <= iCMD_WRITE ? iCMD_WDATA : 32'h0;
                r_tmr    <= '0;
            end else if ((r_state == S_ACCESS) && !w_done && !w_abort) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end

            if (w_done) begin
                r_rsp_vld   <= 1'b1;
                r_rsp_rdata <= r_pwrite ? 32'h0 : iPRDATA;
                r_rsp_err   <= iPSLVERR;
            end else if (w_abort) begin
                r_rsp_vld   <= 1'b1;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign oPSEL      = (r_state != S_IDLE);
    assign oPENABLE   = (r_state == S_ACCESS);
    assign oPWRITE    = r_pwrite;
    assign oPSTRB     = r_pstrb;
    assign oPADDR     = r_paddr;
    assign oPWDATA    = r_pwdata;
    assign oRSP_VALID = r_rsp_vld;
    assign oRSP_RDATA = r_rsp_rdata;
    assign oRSP_ERR   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Purpose : directed bench for apb_master_ctrl with a small SRAM slave model.
// Latency : checks cycle-exact SETUP/ACCESS/response timing.
// Backpr. : drives iPREADY directly to create wait states and stuck transfers.
module tb_apb_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_valid_b;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        pready, pslverr;
    logic [31:0] prdata, prdata_drv;
    logic        slv_sram;

    logic        cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
    logic [31:0] rsp_rdata, pwdata;
    logic [3:0]  pstrb;
    logic [15:0] paddr;

    logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_psel, b_penable, b_pwrite;
    logic [31:0] b_rsp_rdata, b_pwdata;
    logic [3:0]  b_pstrb;
    logic [15:0] b_paddr;

    logic [31:0] mem [256];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    apb_master_ctrl #(.TIMEOUT_CYC(16), .TMR_W(8)) u_dut (
        .iPCLK(clk), .iPRESETn(rst_n),
        .iCMD_VALID(cmd_valid), .oCMD_READY(cmd_ready), .iCMD_WRITE(cmd_write),
        .iCMD_ADDR(cmd_addr), .iCMD_WDATA(cmd_wdata), .iCMD_STRB(cmd_strb),
        .oRSP_VALID(rsp_valid), .oRSP_RDATA(rsp_rdata), .oRSP_ERR(rsp_err),
        .oPSEL(psel), .oPENABLE(penable), .oPWRITE(pwrite), .oPSTRB(pstrb),
        .oPADDR(paddr), .oPWDATA(pwdata),
        .iPRDATA(prdata), .iPREADY(pready), .iPSLVERR(pslverr)
    );

    apb_master_ctrl #(.TIMEOUT_CYC(0), .TMR_W(8)) u_dut_notmo (
        .iPCLK(clk), .iPRESETn(rst_n),
        .iCMD_VALID(cmd_valid_b), .oCMD_READY(b_cmd_ready), .iCMD_WRITE(cmd_write),
        .iCMD_ADDR(cmd_addr), .iCMD_WDATA(cmd_wdata), .iCMD_STRB(cmd_strb),
        .oRSP_VALID(b_rsp_valid), .oRSP_RDATA(b_rsp_rdata), .oRSP_ERR(b_rsp_err),
        .oPSEL(b_psel), .oPENABLE(b_penable), .oPWRITE(b_pwrite), .oPSTRB(b_pstrb),
        .oPADDR(b_paddr), .oPWDATA(b_pwdata),
        .iPRDATA(32'h0), .iPREADY(1'b0), .iPSLVERR(1'b0)
    );

    // SRAM slave lives at PADDR[15:8] == 8'h01, word addressed.
    assign prdata = (slv_sram && paddr[15:8] == 8'h01) ? mem[paddr[9:2]] : prdata_drv;

    always @(negedge clk) begin
        if (psel && penable && pready && pwrite && slv_sram && paddr[15:8] == 8'h01) begin
            for (int i = 0; i < 4; i++) begin
                if (pstrb[i]) mem[paddr[9:2]][8*i +: 8] <= pwdata[8*i +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_chk++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, pstrb, paddr, pwdata} !== 90'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_a: got %h, want 0",
                     {cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, pstrb, paddr, pwdata});
        end
        n_chk++;
        if ({b_cmd_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_psel, b_penable, b_pwrite, b_pstrb, b_paddr, b_pwdata} !== 90'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_b: got %h, want 0",
                     {b_cmd_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err, b_psel, b_penable, b_pwrite, b_pstrb, b_paddr, b_pwdata});
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_chk++;
        if ({cmd_ready, psel, penable, rsp_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_release_idle: ready/psel/penable/rsp got %b, want 1000",
                     {cmd_ready, psel, penable, rsp_valid});
        end
    endtask

    // One zero-wait-state transfer against the SRAM slave, checked cycle by cycle.
    task automatic test_sram_xfer(input bit wr, input logic [15:0] a, input logic [31:0] d,
                                  input logic [3:0] s, input logic [31:0] exp_rd, input string nm);
        logic [52:0] exp_bus;
        exp_bus = {wr, a, (wr ? s : 4'h0), (wr ? d : 32'h0)};
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_c0_ready: got %b, want 1", nm, cmd_ready);
        end
        tick();
        // Cycle 1: SETUP. Scramble the command inputs to prove they are not reused.
        cmd_valid = 1'b0; cmd_addr = 16'hFFFF; cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF; cmd_write = ~wr;
        n_chk++;
        if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1000) begin
            n_fail++; $display("FAIL %s_c1_setup: psel/pen/rdy/rsp got %b, want 1000", nm, {psel, penable, cmd_ready, rsp_valid});
        end
        n_chk++;
        if ({pwrite, paddr, pstrb, pwdata} !== exp_bus) begin
            n_fail++; $display("FAIL %s_c1_bus: got %h, want %h", nm, {pwrite, paddr, pstrb, pwdata}, exp_bus);
        end
        tick();
        // Cycle 2: ACCESS, completes at the next edge.
        n_chk++;
        if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1100) begin
            n_fail++; $display("FAIL %s_c2_access: psel/pen/rdy/rsp got %b, want 1100", nm, {psel, penable, cmd_ready, rsp_valid});
        end
        n_chk++;
        if ({pwrite, paddr, pstrb, pwdata} !== exp_bus) begin
            n_fail++; $display("FAIL %s_c2_bus: got %h, want %h", nm, {pwrite, paddr, pstrb, pwdata}, exp_bus);
        end
        tick();
        // Cycle 3: response pulse, back in IDLE, bus attributes held.
        n_chk++;
        if ({rsp_valid, rsp_err, rsp_rdata, psel, penable, cmd_ready} !== {2'b10, exp_rd, 3'b001}) begin
            n_fail++; $display("FAIL %s_c3_rsp: vld/err/rdata/psel/pen/rdy got %h, want %h", nm,
                               {rsp_valid, rsp_err, rsp_rdata, psel, penable, cmd_ready}, {2'b10, exp_rd, 3'b001});
        end
        n_chk++;
        if ({pwrite, paddr, pstrb, pwdata} !== exp_bus) begin
            n_fail++; $display("FAIL %s_c3_hold: got %h, want %h", nm, {pwrite, paddr, pstrb, pwdata}, exp_bus);
        end
        tick();
        n_chk++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
            n_fail++; $display("FAIL %s_c4_rsp_clear: got %h, want 0", nm, {rsp_valid, rsp_err, rsp_rdata});
        end
    endtask

    task automatic test_wait_states();
        slv_sram = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata_drv = 32'h0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0400; cmd_wdata = 32'h0; cmd_strb = 4'h0;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({psel, penable, rsp_valid} !== 3'b110) begin
                n_fail++; $display("FAIL wait_stall_%0d: psel/pen/rsp got %b, want 110", i, {psel, penable, rsp_valid});
            end
            tick();
        end
        // Cycle 5: fourth ACCESS cycle, slave finally ready with an error.
        pready = 1'b1; pslverr = 1'b1; prdata_drv = 32'hA5A5_0001;
        n_chk++;
        if ({psel, penable} !== 2'b11) begin
            n_fail++; $display("FAIL wait_c5_access: psel/pen got %b, want 11", {psel, penable});
        end
        tick();
        n_chk++;
        if ({rsp_valid, rsp_err, rsp_rdata, psel, cmd_ready} !== {2'b11, 32'hA5A5_0001, 2'b01}) begin
            n_fail++; $display("FAIL wait_c6_rsp: vld/err/rdata/psel/rdy got %h, want %h",
                               {rsp_valid, rsp_err, rsp_rdata, psel, cmd_ready}, {2'b11, 32'hA5A5_0001, 2'b01});
        end
        // Back-to-back: second command offered in the response cycle.
        pslverr = 1'b0; prdata_drv = 32'h0; slv_sram = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0104;
        tick();
        cmd_valid = 1'b0;
        n_chk++;
        if ({psel, penable, paddr} !== {2'b10, 16'h0104}) begin
            n_fail++; $display("FAIL b2b_c7_setup: psel/pen/paddr got %h, want %h", {psel, penable, paddr}, {2'b10, 16'h0104});
        end
        tick();
        tick();
        n_chk++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hDEAD_5678}) begin
            n_fail++; $display("FAIL b2b_c9_rsp: got %h, want %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'hDEAD_5678});
        end
        tick();
    endtask

    task automatic test_timeout();
        int n_acc;
        int k;
        slv_sram = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata_drv = 32'h1234_5678;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0300;
        tick();
        cmd_valid = 1'b0;
        n_acc = 0;
        k = 0;
        while (psel && k < 40) begin
            if (penable) n_acc++;
            tick();
            k++;
        end
        n_chk++;
        if (k >= 40) begin
            n_fail++; $display("FAIL timeout_bound: psel still high after %0d cycles, want drop after 17", k);
        end
        n_chk++;
        if (n_acc != 16) begin
            n_fail++; $display("FAIL timeout_access_cycles: got %0d, want 16", n_acc);
        end
        n_chk++;
        if ({rsp_valid, rsp_err, rsp_rdata, psel, penable, cmd_ready} !== {2'b11, 32'h0, 3'b001}) begin
            n_fail++; $display("FAIL timeout_rsp: vld/err/rdata/psel/pen/rdy got %h, want %h",
                               {rsp_valid, rsp_err, rsp_rdata, psel, penable, cmd_ready}, {2'b11, 32'h0, 3'b001});
        end
        pready = 1'b1; prdata_drv = 32'h0;
        tick();
    endtask

    task automatic test_timeout_disabled();
        logic seen;
        seen = 1'b0;
        cmd_valid_b = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0500;
        tick();
        cmd_valid_b = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            seen = seen | b_rsp_valid;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL notmo_no_rsp: rsp_valid seen %b, want 0", seen);
        end
        n_chk++;
        if ({b_psel, b_penable, b_cmd_ready} !== 3'b110) begin
            n_fail++; $display("FAIL notmo_still_access: psel/pen/rdy got %b, want 110", {b_psel, b_penable, b_cmd_ready});
        end
    endtask

    task automatic test_reset_mid_access();
        slv_sram = 1'b0; pready = 1'b0; pslverr = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0108; cmd_wdata = 32'hCAFE_F00D; cmd_strb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_chk++;
        if ({psel, penable} !== 2'b11) begin
            n_fail++; $display("FAIL rstmid_pre_access: psel/pen got %b, want 11", {psel, penable});
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, pstrb, paddr, pwdata} !== 90'h0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %h, want 0",
                               {cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, pstrb, paddr, pwdata});
        end
        n_chk++;
        if ({b_cmd_ready, b_rsp_valid, b_psel, b_penable} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_outputs_b: rdy/rsp/psel/pen got %b, want 0000",
                               {b_cmd_ready, b_rsp_valid, b_psel, b_penable});
        end
        pready = 1'b1;
        tick();
        n_chk++;
        if ({rsp_valid, psel, cmd_ready} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_held: rsp/psel/rdy got %b, want 000", {rsp_valid, psel, cmd_ready});
        end
        rst_n = 1'b1;
        #1;
        n_chk++;
        if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
            n_fail++; $display("FAIL rstmid_release: rdy/psel/rsp got %b, want 100", {cmd_ready, psel, rsp_valid});
        end
        slv_sram = 1'b1;
        test_sram_xfer(1'b0, 16'h0104, 32'h0, 4'hF, 32'hDEAD_5678, "rd_after_rst");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        cmd_valid = 1'b0; cmd_valid_b = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0;
        cmd_wdata = 32'h0; cmd_strb = 4'h0;
        pready = 1'b1; pslverr = 1'b0; prdata_drv = 32'h0; slv_sram = 1'b1;

        test_reset();
        test_sram_xfer(1'b1, 16'h0104, 32'hDEAD_BEEF, 4'hF, 32'h0,        "wr_full");
        test_sram_xfer(1'b0, 16'h0104, 32'h5555_AAAA, 4'hC, 32'hDEAD_BEEF, "rd_full");
        test_sram_xfer(1'b1, 16'h0104, 32'h1234_5678, 4'h3, 32'h0,        "wr_strb3");
        test_sram_xfer(1'b0, 16'h0104, 32'h0,         4'h0, 32'hDEAD_5678, "rd_merged");
        test_sram_xfer(1'b1, 16'h0104, 32'hFFFF_FFFF, 4'h0, 32'h0,        "wr_strb0");
        test_sram_xfer(1'b0, 16'h0104, 32'h0,         4'h0, 32'hDEAD_5678, "rd_unchanged");
        test_wait_states();
        test_timeout();
        test_timeout_disabled();
        test_reset_mid_access();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "global timeout");
    end

endmodule
